// File: rtl/t05_wb_master_bridge_pkg.sv
// Shared types and constants for the SRAM-requester to Wishbone bridge.
package t05_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        HOLD = 2'd2
    } wb_state_t;

    localparam logic [31:0] WB_ERR_DATA = 32'hFFFF_FFFF;

    // Requester-side region bases
    localparam logic [31:0] HIST_BASE     = 32'd0;
    localparam logic [31:0] HTREE_BASE    = 32'd1024;
    localparam logic [31:0] CODEBOOK_BASE = 32'd2048;

endpackage

// File: rtl/t05_wb_master_bridge_if.sv
// Wishbone B4 classic signal bundle between the bridge (master) and the fabric (slave).
interface t05_wb_master_bridge_if;

    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        err_i;

    modport master (
        output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
        input  dat_i, ack_i, err_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
        output dat_i, ack_i, err_i
    );

endinterface

// File: rtl/t05_wb_master_bridge.sv
// Single-outstanding Wishbone classic master: one bus cycle per level request,
// with ack timeout and sticky timeout/bus-error status.
//
// state | meaning
// IDLE  | waiting for r_en/wr_en; request latched on the sampling edge
// BUS   | cyc/stb asserted, waiting for ack/err or timeout
// HOLD  | cycle finished; waiting for both enables low before re-arming
module t05_wb_master_bridge
    import t05_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = WB_ERR_DATA
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   r_en,
    input  logic                   wr_en,
    input  logic [3:0]             select,
    input  logic [31:0]            addr,
    input  logic [31:0]            data_i,
    output logic [31:0]            data_o,
    output logic                   busy_o,
    output logic                   xfer_done,
    t05_wb_master_bridge_if.master wb,
    input  logic                   clr_status,
    output logic                   timeout_flag,
    output logic                   bus_err_flag
);

    localparam logic [16:0] TO_LIMIT = 17'(TIMEOUT_CYCLES);

    wb_state_t   state_q, state_d;
    logic [15:0] cnt_q, cnt_d, cnt_inc;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] rdata_q, rdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        to_q, to_d;
    logic        be_q, be_d;
    logic        complete, to_set, be_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
            be_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            to_q    <= to_d;
            be_q    <= be_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cyc_d    = cyc_q;
        we_d     = we_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        rdata_d  = rdata_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        complete = 1'b0;
        to_set   = 1'b0;
        be_set   = 1'b0;
        cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

        case (state_q)
            IDLE: begin
                if (r_en || wr_en) begin
                    state_d = BUS;
                    adr_d   = addr & ~32'h3;
                    dat_d   = data_i;
                    sel_d   = select;
                    we_d    = wr_en;
                    cyc_d   = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            BUS: begin
                cnt_d = cnt_inc;
                // err outranks ack when a slave raises both
                if (wb.err_i) begin
                    complete = 1'b1;
                    be_set   = 1'b1;
                    if (!we_q) rdata_d = ERR_DATA;
                end else if (wb.ack_i) begin
                    complete = 1'b1;
                    if (!we_q) rdata_d = wb.dat_i;
                end else if ({1'b0, cnt_inc} >= TO_LIMIT) begin
                    complete = 1'b1;
                    to_set   = 1'b1;
                    if (!we_q) rdata_d = ERR_DATA;
                end
            end
            HOLD: begin
                if (!r_en && !wr_en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            state_d = HOLD;
            cyc_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end

        // a set on the same edge as a clear must survive
        to_d = to_set | (to_q & ~clr_status);
        be_d = be_set | (be_q & ~clr_status);
    end

    assign wb.cyc_o     = cyc_q;
    assign wb.stb_o     = cyc_q;
    assign wb.we_o      = we_q;
    assign wb.adr_o     = adr_q;
    assign wb.dat_o     = dat_q;
    assign wb.sel_o     = sel_q;
    assign data_o       = rdata_q;
    assign busy_o       = busy_q;
    assign xfer_done    = done_q;
    assign timeout_flag = to_q;
    assign bus_err_flag = be_q;

endmodule

// File: doc/t05_wb_master_bridge.md
Name: t05_wb_master_bridge

Overview:
Single-outstanding Wishbone B4 classic master between the team's SRAM-interface block and the SRAM/Wishbone fabric. It converts the level-style r_en/wr_en word requests into exactly one Wishbone cycle per request. It returns read data and drives busy_o back to the requester. It also adds ack timeout, bus-error capture and sticky status for the controller.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in BUS without ack/err before abort (1..65535)
ERR_DATA, 32'hFFFF_FFFF, value loaded into data_o on aborted/errored read

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
r_en  input  1  read request (level)
wr_en  input  1  write request (level); wins if r_en also high
select  input  4  byte lanes
addr  input  32  byte address
data_i  input  32  write data from requester
data_o  output  32  read data to requester
busy_o  output  1  high while a request is in flight
xfer_done  output  1  one-cycle pulse on completion (ack, err or timeout)
cyc_o  output  1  Wishbone CYC
stb_o  output  1  Wishbone STB
we_o  output  1  Wishbone WE
adr_o  output  32  Wishbone address, word aligned
dat_o  output  32  Wishbone write data
sel_o  output  4  Wishbone SEL
dat_i  input  32  Wishbone read data
ack_i  input  1  Wishbone ACK
err_i  input  1  Wishbone ERR
clr_status  input  1  synchronous clear of sticky flags
timeout_flag  output  1  sticky: a cycle timed out
bus_err_flag  output  1  sticky: a cycle ended with err_i

Behaviour:
- Reset (async): state IDLE. All outputs 0, including data_o, busy_o, xfer_done, cyc_o, stb_o, we_o, adr_o, dat_o, sel_o and both flags. Timeout counter 0. A reset mid-cycle drops cyc_o/stb_o immediately; no completion pulse.
- FSM states: IDLE, BUS, HOLD.
- IDLE:
  - If r_en|wr_en is high at a clock edge, latch into adr_o/dat_o/sel_o/we_o on that edge and go to BUS.
  - Latched values: adr_o={addr[31:2],2'b00}; dat_o=data_i; sel_o=select; we_o=wr_en.
  - On the same edge, set cyc_o=stb_o=1 and busy_o=1, and clear the counter.
  - Latency: request sampled at edge N, so cyc/stb are high from N.
- BUS:
  - Hold cyc_o/stb_o and all latched values stable. Requester inputs are ignored.
  - Counter increments each cycle.
  - ack_i: drop cyc/stb/busy, pulse xfer_done, go to HOLD. On a read, also set data_o<=dat_i.
  - err_i (takes priority over ack_i if both are high): same exits, plus bus_err_flag<=1. On a read, data_o<=ERR_DATA.
  - Timeout when the counter reaches TIMEOUT_CYCLES with no ack/err: same exits, plus timeout_flag<=1. On a read, data_o<=ERR_DATA.
  - Write completion leaves data_o unchanged.
- HOLD:
  - Wait until r_en==0 and wr_en==0, then go to IDLE (one new request per enable assertion).
  - busy_o=0 in HOLD.
  - A request already pending when entering HOLD is not re-issued.
- data_o holds its value until the next read completes.
- xfer_done is high exactly one cycle, the cycle after completion sampled.
- clr_status=1 clears both flags next edge. If a set and a clear occur on the same edge, the set wins.
- Counter is 16 bits and saturates. TIMEOUT_CYCLES=1 aborts after 1 cycle without ack.
- Wishbone rules: stb_o==cyc_o at all times. No back-to-back cycles; minimum 1 idle cycle (HOLD) between cycles.

Decomposition:
- Shared package t05_pkg: wb_state_t enum (IDLE, BUS, HOLD); constant WB_ERR_DATA; base-address constants (HIST 0, HTREE 1024, CODEBOOK 2048) used by the requester.
- No sub-module. The timeout counter and sticky-flag logic are inline; total around 150 lines.

Test Plan:
- Write: wr_en=1, addr=0x0000_0404, data_i=0xA5A5_1234, sel=F; slave acks in cycle 2 -> adr_o=0x404, we_o=1, dat_o=0xA5A5_1234, one xfer_done, busy_o high 2 cycles, exactly one cycle issued.
- Read: r_en held 3 cycles, addr=0x802 (misaligned), dat_i=0xCAFE_F00D with ack on cycle 1 -> adr_o=0x800, data_o=0xCAFE_F00D, only one Wishbone cycle despite the long r_en.
- Timeout: TIMEOUT_CYCLES=4, read with no ack -> cyc_o drops after 4 cycles, data_o=0xFFFF_FFFF, timeout_flag=1; clr_status -> flag 0.
- Error: write, slave returns err_i and ack_i together -> bus_err_flag=1, data_o unchanged, xfer_done pulses once.
- Priority: r_en=wr_en=1 -> we_o=1 write cycle.
- Reset mid-cycle: assert rst while in BUS -> cyc_o/stb_o/busy_o 0 asynchronously, no xfer_done; after release, a new read completes normally.
